// File: rtl/ctrl_pipe.sv
// Decode-to-execute control stage: decodes opcodes into a registered
// control bundle with load-use hazard bubbles and multiplier occupancy.
module ctrl_pipe #(
  parameter int OP_W        = 8,
  parameter int RA_W        = 5,
  parameter int MUL_LAT     = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        op,
  input  logic [RA_W-1:0]        rs_a,
  input  logic [RA_W-1:0]        rs_b,
  input  logic [RA_W-1:0]        rd,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             alu_src,
  output logic [3:0]             alu_op,
  output logic                   alu_op2,
  output logic                   mem_sign_ext,
  output logic                   pc_src,
  output logic [3:0]             mem_read,
  output logic [3:0]             mem_write,
  output logic                   rb_select,
  output logic [1:0]             mem_to_reg,
  output logic                   reg_write,
  output logic [RA_W-1:0]        out_rd,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [1:0] alu_src;
    logic [3:0] alu_op;
    logic       alu_op2;
    logic       mem_sign_ext;
    logic       pc_src;
    logic [3:0] mem_read;
    logic [3:0] mem_write;
    logic       rb_select;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {RUN, MUL_BUSY} state_t;

  localparam int CW = 5;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_vld_q, out_vld_d;
  ctrl_t                  bun_q, bun_d;
  logic [RA_W-1:0]        rd_q, rd_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  ctrl_t           dec;
  logic            is_r, is_i;
  logic [OP_W-1:0] op_hi;
  logic            load_en, hazard, accept, xfer;

  // opcode decode into a control bundle
  always_comb begin
    dec   = '0;
    is_r  = 1'b0;
    is_i  = 1'b0;
    op_hi = op >> 8;
    case (op[7:0])
      8'h08: begin is_r = 1'b1; dec.alu_op = 4'd0; end
      8'h10: begin is_r = 1'b1; dec.alu_op = 4'd1; end
      8'h18: begin is_r = 1'b1; dec.alu_op = 4'd2; end
      8'h38: begin is_r = 1'b1; dec.alu_op = 4'd3; end
      8'h30: begin is_r = 1'b1; dec.alu_op = 4'd4; end
      8'h28: begin is_r = 1'b1; dec.alu_op = 4'd5; end
      8'h40: begin is_r = 1'b1; dec.alu_op = 4'd9; end
      8'h07: begin
        is_r        = 1'b1;
        dec.alu_op  = 4'd2;
        dec.alu_op2 = 1'b1;
      end
      8'h03: begin is_i = 1'b1; dec.alu_op = 4'd0; end
      8'h0B: begin is_i = 1'b1; dec.alu_op = 4'd1; end
      8'h13: begin is_i = 1'b1; dec.alu_op = 4'd2; end
      8'h23: begin is_i = 1'b1; dec.alu_op = 4'd3; end
      8'h1B: begin is_i = 1'b1; dec.alu_op = 4'd4; end
      8'h2B: begin is_i = 1'b1; dec.alu_op = 4'd5; end
      8'h19, 8'h11, 8'h09: begin
        dec.rb_select = 1'b1;
        dec.alu_src   = 2'b01;
        dec.mem_write = (op[7:0] == 8'h19) ? 4'b1111 :
                        (op[7:0] == 8'h11) ? 4'b0011 : 4'b0001;
      end
      8'h31, 8'h29, 8'h21, 8'h51, 8'h49: begin
        dec.reg_write    = 1'b1;
        dec.rb_select    = 1'b1;
        dec.alu_src      = 2'b01;
        dec.mem_sign_ext = (op[7:0] == 8'h51) || (op[7:0] == 8'h49);
        dec.mem_read     = (op[7:0] == 8'h31) ? 4'b1111 :
                           (op[7:0] == 8'h29 || op[7:0] == 8'h51) ?
                           4'b0011 : 4'b0001;
      end
      8'h04: begin
        dec.mem_to_reg = 2'b10;
        dec.reg_write  = 1'b1;
        dec.pc_src     = 1'b1;
      end
      8'h00: dec = '0;
      default: dec.illegal = 1'b1;
    endcase
    if (is_r || is_i) begin
      dec.mem_to_reg = 2'b01;
      dec.reg_write  = 1'b1;
    end
    if (is_i) dec.alu_src = 2'b01;
    if (op_hi != '0) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // handshake, hazard detection and next-state for all registers
  always_comb begin
    out_valid = out_vld_q && (state_q == RUN);
    xfer      = out_valid && out_ready;
    load_en   = !out_vld_q || xfer;
    hazard    = out_vld_q && (bun_q.mem_read != '0) && (rd_q != '0)
                && ((rs_a == rd_q) || (rs_b == rd_q));
    in_ready  = load_en && (state_q == RUN) && !hazard && !flush && !rst;
    accept    = in_valid && in_ready;

    state_d   = state_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q;
    bun_d     = bun_q;
    rd_d      = rd_q;
    stall_d   = stall_q;

    if (in_valid && !in_ready && (stall_q != '1))
      stall_d = stall_q + 1'b1;

    if (flush) begin
      out_vld_d = 1'b0;
      bun_d     = '0;
      rd_d      = '0;
      state_d   = RUN;
      cnt_d     = '0;
    end else begin
      if (load_en) begin
        out_vld_d = accept;
        bun_d     = accept ? dec : '0;
        rd_d      = accept ? rd : '0;
      end
      unique case (state_q)
        RUN: begin
          if (xfer && (bun_q.alu_op == 4'd2) && (MUL_LAT > 1)) begin
            state_d = MUL_BUSY;
            cnt_d   = CW'(MUL_LAT - 1);
          end
        end
        MUL_BUSY: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      bun_q     <= '0;
      rd_q      <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      bun_q     <= bun_d;
      rd_q      <= rd_d;
      stall_q   <= stall_d;
    end
  end

  assign alu_src      = bun_q.alu_src;
  assign alu_op       = bun_q.alu_op;
  assign alu_op2      = bun_q.alu_op2;
  assign mem_sign_ext = bun_q.mem_sign_ext;
  assign pc_src       = bun_q.pc_src;
  assign mem_read     = bun_q.mem_read;
  assign mem_write    = bun_q.mem_write;
  assign rb_select    = bun_q.rb_select;
  assign mem_to_reg   = bun_q.mem_to_reg;
  assign reg_write    = bun_q.reg_write;
  assign illegal      = bun_q.illegal;
  assign out_rd       = rd_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: random and directed traffic against a
// transaction-level model with a bundle scoreboard.
module tb_ctrl_pipe;
  localparam int MUL_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] op = '0;
  logic [4:0] rs_a = '0, rs_b = '0, rd = '0;
  logic       in_ready, out_valid;
  logic [1:0] alu_src, mem_to_reg;
  logic [3:0] alu_op, mem_read, mem_write;
  logic       alu_op2, mem_sign_ext, pc_src, rb_select;
  logic       reg_write, illegal;
  logic [4:0] out_rd;
  logic [15:0] stall_cnt;

  ctrl_pipe #(
    .OP_W(8), .RA_W(5), .MUL_LAT(MUL_LAT), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_src(alu_src), .alu_op(alu_op), .alu_op2(alu_op2),
    .mem_sign_ext(mem_sign_ext), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write),
    .rb_select(rb_select), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .out_rd(out_rd), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t        expq[$];
  logic [21:0] tab[int];
  bit          is_ld[int];
  bit          is_mul[int];
  int          legal[$];
  int          n_tests = 0;
  int          n_fail = 0;

  bit       m_held, m_ld, m_mul;
  int       m_busy, m_stall;
  logic [4:0] m_rd;

  wire [21:0] dut_b = {alu_src, alu_op, alu_op2, mem_sign_ext, pc_src,
                       mem_read, mem_write, rb_select, mem_to_reg,
                       reg_write, illegal};

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endfunction

  function automatic logic [21:0] mk(int src, int aop, int op2, int sx,
                                     int pc, int mr, int mw, int rb,
                                     int m2r, int rw);
    return {2'(src), 4'(aop), 1'(op2), 1'(sx), 1'(pc), 4'(mr),
            4'(mw), 1'(rb), 2'(m2r), 1'(rw), 1'b0};
  endfunction

  function automatic void add_alu(int o, int a, int imm, int op2);
    tab[o] = mk(imm, a, op2, 0, 0, 0, 0, 0, 1, 1);
    if (a == 2) is_mul[o] = 1'b1;
    legal.push_back(o);
  endfunction

  function automatic void add_ld(int o, int mr, int sx);
    tab[o] = mk(1, 0, 0, sx, 0, mr, 0, 1, 0, 1);
    is_ld[o] = 1'b1;
    legal.push_back(o);
  endfunction

  function automatic void add_st(int o, int mw);
    tab[o] = mk(1, 0, 0, 0, 0, 0, mw, 1, 0, 0);
    legal.push_back(o);
  endfunction

  function automatic logic [21:0] exp_of(int o);
    if (tab.exists(o)) return tab[o];
    return 22'h1;
  endfunction

  // one clock of stimulus plus cycle-level expectations
  task automatic cyc(input bit iv, input int o, input int ra,
                     input int rb, input int rdi, input bit fl,
                     input bit ordy, input bit r);
    bit ev, xf, room, haz, eir, acc;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    op        = 8'(o);
    rs_a      = 5'(ra);
    rs_b      = 5'(rb);
    rd        = 5'(rdi);
    flush     = fl;
    out_ready = ordy;
    rst       = r;
    #1;
    ev   = m_held && (m_busy == 0);
    xf   = ev && ordy;
    room = !m_held || xf;
    haz  = m_held && m_ld && (m_rd != 0)
           && ((5'(ra) == m_rd) || (5'(rb) == m_rd));
    eir  = room && (m_busy == 0) && !haz && !fl && !r;
    acc  = iv && eir;
    chk("in_ready", in_ready, eir);
    chk("out_valid", out_valid, ev);
    chk("stall_cnt", stall_cnt, m_stall);
    if (!m_held) chk("bubble", {dut_b, out_rd}, 0);
    if (r || fl) begin
      if (m_held && !xf) expq.delete();
      m_held = 1'b0;
      m_busy = 0;
    end else begin
      if (m_busy > 0) m_busy--;
      else if (xf && m_mul && MUL_LAT > 1) m_busy = MUL_LAT - 1;
      if (room) begin
        m_held = acc;
        if (acc) begin
          m_ld  = is_ld.exists(o & 255);
          m_mul = is_mul.exists(o & 255);
          m_rd  = 5'(rdi);
          e.b   = exp_of(o & 255);
          e.rd  = 5'(rdi);
          expq.push_back(e);
        end
      end
    end
    if (r) m_stall = 0;
    else if (iv && !eir && m_stall != 16'hFFFF) m_stall++;
  endtask

  // scoreboard monitor: pops on every bundle transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("bundle", dut_b, e.b);
          chk("out_rd", out_rd, e.rd);
        end
      end
    end
  end

  initial begin
    int o;
    add_alu(8'h08, 0, 0, 0); add_alu(8'h10, 1, 0, 0);
    add_alu(8'h18, 2, 0, 0); add_alu(8'h38, 3, 0, 0);
    add_alu(8'h30, 4, 0, 0); add_alu(8'h28, 5, 0, 0);
    add_alu(8'h40, 9, 0, 0); add_alu(8'h07, 2, 0, 1);
    add_alu(8'h03, 0, 1, 0); add_alu(8'h0B, 1, 1, 0);
    add_alu(8'h13, 2, 1, 0); add_alu(8'h23, 3, 1, 0);
    add_alu(8'h1B, 4, 1, 0); add_alu(8'h2B, 5, 1, 0);
    add_st(8'h19, 15); add_st(8'h11, 3); add_st(8'h09, 1);
    add_ld(8'h31, 15, 0); add_ld(8'h29, 3, 0);
    add_ld(8'h21, 1, 0); add_ld(8'h51, 3, 1);
    add_ld(8'h49, 1, 1);
    tab[8'h04] = mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 1);
    tab[8'h00] = 22'h0;
    legal.push_back(8'h04);
    legal.push_back(8'h00);

    m_held = 0; m_ld = 0; m_mul = 0; m_busy = 0; m_stall = 0; m_rd = 0;
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("reset_stall", stall_cnt, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) o = $urandom_range(0, 255);
      else o = legal[$urandom_range(0, legal.size() - 1)];
      cyc(($urandom_range(0, 3) != 0), o, $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 149) == 0));
    end

    // ADD produces an R-type bundle next cycle
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 8'h08, 1, 2, 6, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("add_valid", out_valid, 1);
    chk("add_m2r", mem_to_reg, 2'b01);
    chk("add_rw", reg_write, 1);
    chk("add_ill", illegal, 0);

    // load-use hazard: LW r3 then ADD using r3
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 8'h31, 0, 0, 3, 0, 1, 0);
    cyc(1, 8'h08, 3, 1, 4, 0, 1, 0);
    cyc(1, 8'h08, 3, 1, 4, 0, 1, 0);
    chk("hazard_bubble", out_valid, 0);
    chk("hazard_stall", stall_cnt, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("hazard_add", out_valid, 1);

    // MUL occupancy then XOR
    cyc(1, 8'h18, 1, 2, 5, 0, 1, 0);
    cyc(1, 8'h38, 1, 2, 6, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("mul_busy_ov", out_valid, 0);
    chk("mul_busy_ir", in_ready, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("xor_after_mul", out_valid, 1);
    chk("xor_aluop", alu_op, 3);

    // illegal opcode and NOP
    cyc(1, 8'h55, 0, 0, 1, 0, 1, 0);
    cyc(1, 8'h00, 0, 0, 2, 0, 1, 0);
    chk("ill_flag", illegal, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("nop_ill", illegal, 0);

    // flush a held store
    cyc(1, 8'h19, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_ov", out_valid, 0);
    chk("flush_mw", mem_write, 0);
    chk("flush_ir", in_ready, 1);

    // drain and confirm every accepted bundle came out
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("queue_empty", expq.size(), 0);

    // stall counter saturation
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 70000; i++) cyc(1, 8'h08, 1, 2, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_reset", stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
